// File: rtl/pipe_stage_reg_if.sv
// Payload bus between two pipeline stages: upstream slot in, registered slot out.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (output in_valid, output in_data, input  out_valid, input  out_data);
    modport slave  (input  in_valid, input  in_data, output out_valid, output out_data);
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall/bubble/flush control and
// saturating event counters; STAGE selects which stall_en bits govern it.
module pipe_stage_reg #(
    parameter int                CNT_W      = 16,
    parameter int                DATA_W     = 64,
    parameter int                STALL_W    = 6,
    parameter int                STAGE      = 1,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STALL_W-1:0] stall_en,
    input  logic               flush,
    input  logic               cnt_clr,
    pipe_stage_reg_if.slave    bus,
    output logic               hold,
    output logic [CNT_W-1:0]   hold_len,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef enum logic [1:0] {ACT_ADV, ACT_FLUSH, ACT_BUBBLE, ACT_HOLD} act_e;

    act_e              act;
    logic              s_up, s_dn;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  hold_len_q, hold_len_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              unused_stall;

    generate
        if (STAGE >= STALL_W) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE must be below STALL_W");
        end
        // The last stage has no downstream neighbour, so it can only bubble.
        if (STAGE < STALL_W - 1) begin : g_dn
            assign s_dn = stall_en[STAGE+1];
        end else begin : g_last
            assign s_dn = 1'b0;
        end
    endgenerate

    assign s_up         = stall_en[STAGE];
    assign unused_stall = ^stall_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        act = ACT_ADV;
        if (flush)             act = ACT_FLUSH;
        else if (s_up && !s_dn) act = ACT_BUBBLE;
        else if (s_up)          act = ACT_HOLD;
    end

    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        hold_len_d   = '0;
        hold_cnt_d   = hold_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        case (act)
            ACT_FLUSH: begin
                valid_d     = 1'b0;
                data_d      = BUBBLE_VAL;
                flush_cnt_d = sat_inc(flush_cnt_q);
            end
            ACT_BUBBLE: begin
                valid_d      = 1'b0;
                data_d       = BUBBLE_VAL;
                bubble_cnt_d = sat_inc(bubble_cnt_q);
            end
            ACT_HOLD: begin
                hold_len_d = sat_inc(hold_len_q);
                hold_cnt_d = sat_inc(hold_cnt_q);
            end
            default: begin
                valid_d = bus.in_valid;
                data_d  = bus.in_data;
            end
        endcase
        // Clear wins over a same-cycle event; run length is left alone.
        if (cnt_clr) begin
            hold_cnt_d   = '0;
            bubble_cnt_d = '0;
            flush_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            data_q       <= BUBBLE_VAL;
            hold_len_q   <= '0;
            hold_cnt_q   <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            hold_len_q   <= hold_len_d;
            hold_cnt_q   <= hold_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign hold          = (act == ACT_HOLD) && !reset;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign hold_len      = hold_len_q;
    assign hold_cnt      = hold_cnt_q;
    assign bubble_cnt    = bubble_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: three instances (mid stage, last stage, narrow counters)
// driven by directed vectors; a negedge monitor pops and compares.
module tb_pipe_stage_reg;

    localparam logic [63:0] BV_B = 64'hBBBB_0000_0000_00BB;
    localparam logic [6:0]  ALL  = 7'h7f;
    localparam logic [6:0]  HLD  = 7'h04;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0][5:0]  st;
    logic [2:0]       fl, clr;
    logic [2:0]       o_hold;
    logic [2:0][15:0] o_hl, o_hc, o_bc, o_fc;
    logic [15:0]      a_hl, a_hc, a_bc, a_fc, b_hl, b_hc, b_bc, b_fc;
    logic [3:0]       c_hl, c_hc, c_bc, c_fc;

    pipe_stage_reg_if #(.DATA_W(64)) ifa ();
    pipe_stage_reg_if #(.DATA_W(64)) ifb ();
    pipe_stage_reg_if #(.DATA_W(64)) ifc ();

    pipe_stage_reg #(.DATA_W(64), .STALL_W(6), .STAGE(1), .BUBBLE_VAL(64'h0), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .stall_en(st[0]), .flush(fl[0]), .cnt_clr(clr[0]), .bus(ifa.slave),
        .hold(o_hold[0]), .hold_len(a_hl), .hold_cnt(a_hc), .bubble_cnt(a_bc), .flush_cnt(a_fc));
    pipe_stage_reg #(.DATA_W(64), .STALL_W(6), .STAGE(5), .BUBBLE_VAL(BV_B), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .stall_en(st[1]), .flush(fl[1]), .cnt_clr(clr[1]), .bus(ifb.slave),
        .hold(o_hold[1]), .hold_len(b_hl), .hold_cnt(b_hc), .bubble_cnt(b_bc), .flush_cnt(b_fc));
    pipe_stage_reg #(.DATA_W(64), .STALL_W(6), .STAGE(2), .BUBBLE_VAL(64'h0), .CNT_W(4)) u_c (
        .clk(clk), .reset(reset), .stall_en(st[2]), .flush(fl[2]), .cnt_clr(clr[2]), .bus(ifc.slave),
        .hold(o_hold[2]), .hold_len(c_hl), .hold_cnt(c_hc), .bubble_cnt(c_bc), .flush_cnt(c_fc));

    assign o_hl[0] = a_hl;        assign o_hc[0] = a_hc;        assign o_bc[0] = a_bc;        assign o_fc[0] = a_fc;
    assign o_hl[1] = b_hl;        assign o_hc[1] = b_hc;        assign o_bc[1] = b_bc;        assign o_fc[1] = b_fc;
    assign o_hl[2] = {12'd0, c_hl}; assign o_hc[2] = {12'd0, c_hc}; assign o_bc[2] = {12'd0, c_bc}; assign o_fc[2] = {12'd0, c_fc};

    typedef struct {
        int          sel;
        string       nm;
        logic [6:0]  mask;
        logic        v;
        logic [63:0] d;
        logic        h;
        logic [15:0] hl, hc, bc, fc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input string f, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, f, act, exp);
        end
    endtask

    // Monitor: registered outputs reflect the previous edge, hold the current inputs.
    always @(negedge clk) begin
        #2;
        if (sbq.size() > 0) begin
            exp_t e;
            logic        v;
            logic [63:0] d;
            e = sbq.pop_front();
            v = (e.sel == 0) ? ifa.out_valid : (e.sel == 1) ? ifb.out_valid : ifc.out_valid;
            d = (e.sel == 0) ? ifa.out_data  : (e.sel == 1) ? ifb.out_data  : ifc.out_data;
            if (e.mask[0]) chk(e.nm, "out_valid",  {63'd0, v}, {63'd0, e.v});
            if (e.mask[1]) chk(e.nm, "out_data",   d, e.d);
            if (e.mask[2]) chk(e.nm, "hold",       {63'd0, o_hold[e.sel]}, {63'd0, e.h});
            if (e.mask[3]) chk(e.nm, "hold_len",   {48'd0, o_hl[e.sel]}, {48'd0, e.hl});
            if (e.mask[4]) chk(e.nm, "hold_cnt",   {48'd0, o_hc[e.sel]}, {48'd0, e.hc});
            if (e.mask[5]) chk(e.nm, "bubble_cnt", {48'd0, o_bc[e.sel]}, {48'd0, e.bc});
            if (e.mask[6]) chk(e.nm, "flush_cnt",  {48'd0, o_fc[e.sel]}, {48'd0, e.fc});
        end
    end

    task automatic vec(input int sel, input string nm, input logic rst, input logic [5:0] s,
                       input logic f, input logic iv, input logic [63:0] id, input logic c,
                       input logic [6:0] mask, input logic ev, input logic [63:0] ed, input logic eh,
                       input logic [15:0] ehl, input logic [15:0] ehc, input logic [15:0] ebc,
                       input logic [15:0] efc);
        exp_t e;
        @(negedge clk);
        reset = rst;
        st = '0; fl = '0; clr = '0;
        ifa.in_valid = 1'b0; ifa.in_data = '0;
        ifb.in_valid = 1'b0; ifb.in_data = '0;
        ifc.in_valid = 1'b0; ifc.in_data = '0;
        st[sel] = s; fl[sel] = f; clr[sel] = c;
        case (sel)
            0: begin ifa.in_valid = iv; ifa.in_data = id; end
            1: begin ifb.in_valid = iv; ifb.in_data = id; end
            default: begin ifc.in_valid = iv; ifc.in_data = id; end
        endcase
        e.sel = sel; e.nm = nm; e.mask = mask; e.v = ev; e.d = ed; e.h = eh;
        e.hl = ehl; e.hc = ehc; e.bc = ebc; e.fc = efc;
        sbq.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d1, d2, d6, dA, dB;
        d1 = 64'h0000_0400_2408_0001; d2 = 64'h0000_0400_2408_0002;
        d6 = 64'h0000_0400_2408_0006; dA = 64'h0000_0000_0000_00AA;
        dB = 64'h0000_0000_0000_00BB;
        st = '0; fl = '0; clr = '0;
        ifa.in_valid = 1'b0; ifa.in_data = '0;
        ifb.in_valid = 1'b0; ifb.in_data = '0;
        ifc.in_valid = 1'b0; ifc.in_data = '0;

        // Instance A: STAGE=1, 16-bit counters, BUBBLE_VAL=0
        //   sel nm            rst stall      fl iv data     clr mask v  data h  hl  hc  bc  fc
        vec(0, "a_rst0",       1, 6'b000110, 0, 0, 64'h0,   0, ALL, 0, 0,  0, 0,  0,  0,  0);
        vec(0, "a_rst1",       1, 6'b000000, 0, 1, 64'h99,  0, ALL, 0, 0,  0, 0,  0,  0,  0);
        vec(0, "a_adv_in",     0, 6'b000000, 0, 1, d1,      0, ALL, 0, 0,  0, 0,  0,  0,  0);
        vec(0, "a_adv_out",    0, 6'b000000, 0, 1, d2,      0, ALL, 1, d1, 0, 0,  0,  0,  0);
        vec(0, "a_hold1",      0, 6'b000110, 0, 1, 64'h3,   0, ALL, 1, d2, 1, 0,  0,  0,  0);
        vec(0, "a_hold2",      0, 6'b000110, 0, 1, 64'h4,   0, ALL, 1, d2, 1, 1,  1,  0,  0);
        vec(0, "a_hold3",      0, 6'b000110, 0, 1, 64'h5,   0, ALL, 1, d2, 1, 2,  2,  0,  0);
        vec(0, "a_release",    0, 6'b000000, 0, 1, d6,      0, ALL, 1, d2, 0, 3,  3,  0,  0);
        vec(0, "a_bubble",     0, 6'b000010, 0, 1, 64'h7,   0, ALL, 1, d6, 0, 0,  3,  0,  0);
        vec(0, "a_flush",      0, 6'b000110, 1, 1, 64'h8,   0, ALL, 0, 0,  0, 0,  3,  1,  0);
        vec(0, "a_hold_inv",   0, 6'b000110, 0, 1, 64'h9,   0, ALL, 0, 0,  1, 0,  3,  1,  1);
        vec(0, "a_ignored",    0, 6'b111001, 0, 0, dA,      0, ALL, 0, 0,  0, 1,  4,  1,  1);
        vec(0, "a_clr",        0, 6'b000000, 0, 1, dB,      1, ALL, 0, dA, 0, 0,  4,  1,  1);
        vec(0, "a_hold_pre",   0, 6'b000110, 0, 1, 64'hC,   0, ALL, 1, dB, 1, 0,  0,  0,  0);
        vec(0, "a_rst_mid",    1, 6'b000110, 0, 1, 64'hD,   0, ALL, 1, dB, 0, 1,  1,  0,  0);
        vec(0, "a_rst_done",   0, 6'b000000, 0, 0, 64'h0,   0, ALL, 0, 0,  0, 0,  0,  0,  0);

        // Instance B: last stage, s_dn forced low so a stall always bubbles
        vec(1, "b_rst",        1, 6'b000000, 0, 0, 64'h0,   0, HLD, 0, 0,    0, 0, 0, 0, 0);
        vec(1, "b_bubble",     0, 6'b110000, 0, 1, 64'hE1,  0, ALL, 0, BV_B, 0, 0, 0, 0, 0);
        vec(1, "b_adv",        0, 6'b000000, 0, 1, 64'hE2,  0, ALL, 0, BV_B, 0, 0, 0, 1, 0);
        vec(1, "b_bubble2",    0, 6'b100000, 0, 1, 64'hE3,  0, ALL, 1, 64'hE2, 0, 0, 0, 1, 0);
        vec(1, "b_after",      0, 6'b000000, 0, 0, 64'h0,   0, ALL, 0, BV_B, 0, 0, 0, 2, 0);

        // Instance C: STAGE=2, 4-bit counters saturate at 15
        vec(2, "c_rst",        1, 6'b000000, 0, 0, 64'h0,   0, HLD, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            logic [15:0] n;
            n = (k - 1 > 15) ? 16'd15 : 16'(k - 1);
            vec(2, $sformatf("c_hold%0d", k), 0, 6'b001100, 0, 1, 64'(k), 0, ALL, 0, 0, 1, n, n, 0, 0);
        end
        vec(2, "c_clr_hold",   0, 6'b001100, 0, 1, 64'h15,  1, ALL, 0, 0,      1, 15, 15, 0, 0);
        vec(2, "c_release",    0, 6'b000000, 0, 1, 64'hF2,  0, ALL, 0, 0,      0, 15, 0,  0, 0);
        vec(2, "c_after",      0, 6'b000000, 0, 0, 64'h0,   0, ALL, 1, 64'hF2, 0, 0,  0,  0, 0);

        @(negedge clk);
        #5;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
